vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 122 ++++++++++++
 tb/tb_vga_sync_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator. Phase FSMs with down-counters
// produce sync/de; free-running hcnt/vcnt give coordinates; strobes trail by a clk.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_px_en,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_de,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_line_end,
   output logic          o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

   phase_t        h_st, v_st;
   logic [CW-1:0] h_ph, v_ph;
   logic [CW-1:0] hcnt, vcnt;
   logic          line_adv, frame_adv;
   logic          le_pend, fs_pend;

   function automatic phase_t nxt(input phase_t s);
      case (s)
         ACT:     return FP;
         FP:      return SYNC;
         SYNC:    return BP;
         default: return ACT;
      endcase
   endfunction

   function automatic logic [CW-1:0] h_len(input phase_t s);
      case (s)
         ACT:     return CW'(H_ACTIVE - 1);
         FP:      return CW'(H_FRONT - 1);
         SYNC:    return CW'(H_SYNC - 1);
         default: return CW'(H_BACK - 1);
      endcase
   endfunction

   function automatic logic [CW-1:0] v_len(input phase_t s);
      case (s)
         ACT:     return CW'(V_ACTIVE - 1);
         FP:      return CW'(V_FRONT - 1);
         SYNC:    return CW'(V_SYNC - 1);
         default: return CW'(V_BACK - 1);
      endcase
   endfunction

   assign line_adv  = i_px_en && (hcnt == CW'(H_TOTAL - 1));
   assign frame_adv = line_adv && (vcnt == CW'(V_TOTAL - 1));

   // Horizontal phase FSM and pixel counter
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_st <= ACT;
         h_ph <= CW'(H_ACTIVE - 1);
         hcnt <= '0;
      end else if (i_px_en) begin
         hcnt <= line_adv ? '0 : hcnt + CW'(1);
         if (h_ph == '0) begin
            h_st <= nxt(h_st);
            h_ph <= h_len(nxt(h_st));
         end else begin
            h_ph <= h_ph - CW'(1);
         end
      end
   end

   // Vertical phase FSM and line counter, stepped once per line
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_st <= ACT;
         v_ph <= CW'(V_ACTIVE - 1);
         vcnt <= '0;
      end else if (line_adv) begin
         vcnt <= frame_adv ? '0 : vcnt + CW'(1);
         if (v_ph == '0) begin
            v_st <= nxt(v_st);
            v_ph <= v_len(nxt(v_st));
         end else begin
            v_ph <= v_ph - CW'(1);
         end
      end
   end

   // Strobes land one clk after the wrap edge, so they trail the coordinates.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         le_pend       <= 1'b0;
         fs_pend       <= 1'b0;
         o_line_end    <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         le_pend       <= line_adv;
         fs_pend       <= frame_adv;
         o_line_end    <= le_pend;
         o_frame_start <= fs_pend;
      end
   end

   assign o_hsync = (h_st != SYNC);
   assign o_vsync = (v_st != SYNC);
   assign o_de    = (h_st == ACT) && (v_st == ACT);
   assign o_x     = hcnt;
   assign o_y     = vcnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a tiny-timing instance,
// both checked every clk against an arithmetic pixel-count model.
module tb_vga_sync_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       px_en;
   logic       d_hs, d_vs, d_de, d_le, d_fs;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_de, s_le, s_fs;
   logic [4:0] s_x, s_y;

   vga_sync_gen dut (
      .clk(clk), .i_rst_n(rst_n), .i_px_en(px_en),
      .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de), .o_x(d_x), .o_y(d_y),
      .o_line_end(d_le), .o_frame_start(d_fs)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CW(5)
   ) dut_s (
      .clk(clk), .i_rst_n(rst_n), .i_px_en(px_en),
      .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de), .o_x(s_x), .o_y(s_y),
      .o_line_end(s_le), .o_frame_start(s_fs)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     fails  = 0;
   longint p;                       // pixel enables seen since reset
   bit     le_pd, le_ed, fs_pd, fs_ed, le_ps, le_es, fs_ps, fs_es;
   int     cnt_hs, cnt_de, cnt_le, cnt_fs, cnt_sde, cnt_shs, cnt_svs;

   task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Expected outputs from the pixel count alone: position in line and frame.
   task automatic chk_inst(input string n, input int ha, hf, hsw, hb, va, vf, vsw, vb,
                           input logic ohs, ovs, ode, input logic [15:0] ox, oy,
                           input logic ole, ofs, input bit ele, efs);
      int ht, vt, ex, ey;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      ex = int'(p % ht);
      ey = int'((p / ht) % vt);
      cmp({n, "_x"}, ox, 16'(ex));
      cmp({n, "_y"}, oy, 16'(ey));
      cmp({n, "_hsync"}, {15'b0, ohs}, {15'b0, !(ex >= ha + hf && ex < ha + hf + hsw)});
      cmp({n, "_vsync"}, {15'b0, ovs}, {15'b0, !(ey >= va + vf && ey < va + vf + vsw)});
      cmp({n, "_de"}, {15'b0, ode}, {15'b0, (ex < ha && ey < va)});
      cmp({n, "_line_end"}, {15'b0, ole}, {15'b0, ele});
      cmp({n, "_frame_start"}, {15'b0, ofs}, {15'b0, efs});
   endtask

   task automatic chk_all();
      chk_inst("d", 640, 16, 96, 48, 480, 10, 2, 33, d_hs, d_vs, d_de, 16'(d_x), 16'(d_y),
               d_le, d_fs, le_ed, fs_ed);
      chk_inst("s", 8, 2, 2, 2, 4, 1, 1, 1, s_hs, s_vs, s_de, 16'(s_x), 16'(s_y),
               s_le, s_fs, le_es, fs_es);
   endtask

   task automatic chk_rst(input string n);
      cmp({n, "_d_state"}, {9'b0, d_hs, d_vs, d_de, d_le, d_fs, 2'b0}, 16'b0000000_11100_00);
      cmp({n, "_d_xy"}, {6'b0, d_x | d_y}, 16'd0);
      cmp({n, "_s_state"}, {9'b0, s_hs, s_vs, s_de, s_le, s_fs, 2'b0}, 16'b0000000_11100_00);
      cmp({n, "_s_xy"}, {11'b0, s_x | s_y}, 16'd0);
   endtask

   task automatic model_reset();
      p = 0;
      {le_pd, le_ed, fs_pd, fs_ed, le_ps, le_es, fs_ps, fs_es} = '0;
   endtask

   task automatic clr_cnt();
      {cnt_hs, cnt_de, cnt_le, cnt_fs, cnt_sde, cnt_shs, cnt_svs} = '0;
   endtask

   // One clk: drive enable, advance the model at the edge, check at the falling edge.
   task automatic step(input bit en);
      px_en = en;
      @(posedge clk);
      le_ed = le_pd;  le_pd = en && ((p + 1) % 800 == 0);
      fs_ed = fs_pd;  fs_pd = en && ((p + 1) % (800 * 525) == 0);
      le_es = le_ps;  le_ps = en && ((p + 1) % 14 == 0);
      fs_es = fs_ps;  fs_ps = en && ((p + 1) % (14 * 7) == 0);
      if (en) p++;
      @(negedge clk);
      chk_all();
      if (en) begin
         if (!d_hs) cnt_hs++;
         if (d_de)  cnt_de++;
         if (s_de)  cnt_sde++;
         if (!s_hs) cnt_shs++;
         if (!s_vs) cnt_svs++;
      end
      if (d_le) cnt_le++;
      if (s_fs) cnt_fs++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, second, cyc;
      rst_n = 1'b0;
      px_en = 1'b0;
      model_reset();
      #3 chk_rst("rst_async");
      @(negedge clk);
      @(negedge clk);
      chk_rst("rst_held");
      rst_n = 1'b1;

      // Gated enable, one full line
      clr_cnt();
      step(1);
      cmp("first_x", 16'(d_x), 16'd1);
      step(0);
      for (int i = 1; i < 800; i++) begin
         step(1);
         step(0);
      end
      cmp("line_x_wrap", 16'(d_x), 16'd0);
      cmp("line_hs_cnt", 16'(cnt_hs), 16'd96);
      cmp("line_de_cnt", 16'(cnt_de), 16'd640);
      cmp("line_le_cnt", 16'(cnt_le), 16'd1);

      // Back-to-back enables: line period in clks
      first = -1; second = -1; cyc = 0;
      for (int i = 0; i < 1700; i++) begin
         step(1);
         cyc++;
         if (d_le) begin
            if (first < 0) first = cyc;
            else if (second < 0) second = cyc;
         end
      end
      cmp("b2b_period", 16'(second - first), 16'd800);

      // Freeze just before hsync falls
      for (int i = 0; i < 3000 && d_x != 10'd655; i++) step(1'($urandom_range(0, 1)));
      cmp("reach_h655", 16'(d_x), 16'd655);
      clr_cnt();
      repeat (100) step(0);
      cmp("hold_no_le", 16'(cnt_le), 16'd0);
      step(1);
      cmp("resume_hs_fall", {15'b0, d_hs}, 16'd0);
      cmp("resume_x", 16'(d_x), 16'd656);

      // Small timing: freeze at end of the line before vsync, then resume
      for (int i = 0; i < 3000 && !(s_x == 5'd13 && s_y == 5'd4); i++)
         step(1'($urandom_range(0, 1)));
      cmp("reach_s_13_4", {s_y, 3'b0, s_x}, {5'd4, 3'b0, 5'd13});
      clr_cnt();
      repeat (100) step(0);
      step(1);
      cmp("s_resume_vs_fall", {15'b0, s_vs}, 16'd0);
      cmp("s_resume_xy", {s_y, 3'b0, s_x}, {5'd5, 3'b0, 5'd0});

      // Small timing: one frame's worth of pixels, then three random-enable frames
      clr_cnt();
      repeat (98) step(1);
      cmp("s_de_per_frame", 16'(cnt_sde), 16'd32);
      cmp("s_hs_per_frame", 16'(cnt_shs), 16'd14);
      cmp("s_vs_per_frame", 16'(cnt_svs), 16'd14);
      clr_cnt();
      for (int i = 0; i < 3000 && cnt_fs < 3; i++) step(1'($urandom_range(0, 1)));
      cmp("s_three_frames", 16'(cnt_fs), 16'd3);

      // Asynchronous reset mid-hsync, then a full clean line
      for (int i = 0; i < 3000 && d_x != 10'd700; i++) step(1'($urandom_range(0, 1)));
      cmp("reach_h700", 16'(d_x), 16'd700);
      cmp("h700_in_sync", {15'b0, d_hs}, 16'd0);
      px_en = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_rst("rst_mid");
      model_reset();
      @(negedge clk);
      chk_rst("rst_mid_held");
      rst_n = 1'b1;
      clr_cnt();
      repeat (800) step(1);
      step(0);
      cmp("post_rst_x", 16'(d_x), 16'd0);
      cmp("post_rst_hs_cnt", 16'(cnt_hs), 16'd96);
      cmp("post_rst_de_cnt", 16'(cnt_de), 16'd640);
      cmp("post_rst_le_cnt", 16'(cnt_le), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
